// File: rtl/top.sv
// Raster scaler: scans an internal 256x256 test image one position per clock
// and emits a downscaled (N x N) or upscaled (N x N region to 256x256) stream.
//
// Ports:
//   clk          - system clock, rising edge
//   rst_n        - asynchronous active-low reset
//   convert_type - scaling mode, sampled at the start of every frame
//   LCD_RGB      - RGB565 output pixel, registered, holds when write_en = 0
//   write_en     - high when LCD_RGB carries a valid pixel for this position
module top (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  convert_type,
   output logic [15:0] LCD_RGB,
   output logic        write_en
);

   localparam logic [2:0] DS_192 = 3'd0;
   localparam logic [2:0] DS_128 = 3'd1;
   localparam logic [2:0] DS_96  = 3'd2;
   localparam logic [2:0] DS_64  = 3'd3;
   localparam logic [2:0] US_192 = 3'd4;
   localparam logic [2:0] US_128 = 3'd5;
   localparam logic [2:0] US_96  = 3'd6;
   localparam logic [2:0] US_64  = 3'd7;

   // Test image: column and row bit fields plus their XOR in the low field.
   function automatic logic [15:0] src(input logic [4:0] cx, input logic [5:0] cy);
      return {cx, cy, cx ^ cy[5:1]};
   endfunction

   logic [15:0] pos_q;
   logic [2:0]  mode_q;
   logic [7:0]  acc_x_q, acc_y_q;
   logic [7:0]  acc_x_d, acc_y_d;

   logic [7:0]  x, y;
   logic [2:0]  mode;
   logic [7:0]  n;
   logic        keep_x, keep_y;
   logic [7:0]  sx, sy;
   logic        emit;
   logic [15:0] pix;

   assign x = pos_q[7:0];
   assign y = pos_q[15:8];

   // Position 0 already uses the mode being sampled for the new frame.
   assign mode = (pos_q == 16'd0) ? convert_type : mode_q;

   always_comb begin
      n = 8'd0;
      unique case (mode)
         DS_192, US_192: n = 8'd192;
         DS_128, US_128: n = 8'd128;
         DS_96,  US_96:  n = 8'd96;
         DS_64,  US_64:  n = 8'd64;
         default:        n = 8'd0;
      endcase
   end

   // Accumulators hold (coord*N) mod 256; a carry out on +N marks a kept line.
   // Both return to zero naturally after coordinate 255, so frames restart clean.
   assign {keep_x, acc_x_d} = {1'b0, acc_x_q} + {1'b0, n};
   assign {keep_y, acc_y_d} = {1'b0, acc_y_q} + {1'b0, n};

   // Upscale source coordinates: (coord*N)>>8, product formed 16 bits wide.
   assign sx = 8'(({8'd0, x} * {8'd0, n}) >> 8);
   assign sy = 8'(({8'd0, y} * {8'd0, n}) >> 8);

   always_comb begin
      emit = 1'b0;
      pix  = 16'h0000;
      if (mode[2]) begin
         emit = 1'b1;
         pix  = src(sx[7:3], sy[7:2]);
      end else begin
         emit = keep_x & keep_y;
         pix  = src(x[7:3], y[7:2]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_q    <= 16'd0;
         // Only consulted once the frame has moved past position 0.
         mode_q   <= 3'd0;
         acc_x_q  <= 8'd0;
         acc_y_q  <= 8'd0;
         LCD_RGB  <= 16'h0000;
         write_en <= 1'b0;
      end else begin
         pos_q   <= pos_q + 16'd1;
         if (pos_q == 16'd0) begin
            mode_q <= convert_type;
         end
         acc_x_q <= acc_x_d;
         if (x == 8'd255) begin
            acc_y_q <= acc_y_d;
         end
         write_en <= emit;
         if (emit) begin
            LCD_RGB <= pix;
         end
      end
   end

endmodule

// File: tb/tb_top.sv
module tb_top;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [2:0]  convert_type = 3'd0;
   logic [15:0] LCD_RGB;
   logic        write_en;

   top dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .convert_type (convert_type),
      .LCD_RGB      (LCD_RGB),
      .write_en     (write_en)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [15:0] pix;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          pulses = 0;
   int          pushed = 0;
   int          p = 0;
   logic [2:0]  mode_m = 3'd0;
   logic [15:0] last_exp = 16'h0000;
   logic [15:0] last_act = 16'h0000;

   // Reference image, written with plain arithmetic.
   function automatic logic [15:0] src_m(input int xx, input int yy);
      int cx, cy, mx;
      cx = xx / 8;
      cy = yy / 4;
      mx = (xx / 8) ^ (yy / 8);
      return 16'(cx * 2048 + cy * 32 + mx);
   endfunction

   function automatic int n_of(input logic [2:0] m);
      case (m % 4)
         0:       return 192;
         1:       return 128;
         2:       return 96;
         default: return 64;
      endcase
   endfunction

   function automatic bit kept(input int c, input int nn);
      return ((c * nn) % 256) + nn >= 256;
   endfunction

   task automatic chk(input bit ok, input string name, input int act, input int exp);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (!rst_n) begin
            chk(write_en === 1'b0 && LCD_RGB === 16'h0000, "reset_outputs",
                {15'd0, write_en, LCD_RGB}, 0);
            last_exp = 16'h0000;
         end else if (write_en === 1'b1) begin
            pulses++;
            last_act = LCD_RGB;
            if (sb.size() == 0) begin
               chk(1'b0, "unexpected_pulse", cyc, -1);
            end else begin
               e = sb.pop_front();
               chk(e.cyc == cyc, "pulse_cycle", cyc, e.cyc);
               chk(LCD_RGB === e.pix, "pixel", int'(LCD_RGB), int'(e.pix));
               last_exp = e.pix;
            end
         end else begin
            chk(write_en === 1'b0 && LCD_RGB === last_exp, "idle_hold",
                {15'd0, write_en, LCD_RGB}, int'(last_exp));
         end
      end
   endtask

   // Drive ncyc positions, pushing the expected pixel for each emitted one.
   task automatic run(input int ncyc);
      int xx, yy, nn;
      exp_t e;
      for (int i = 0; i < ncyc; i++) begin
         xx = p % 256;
         yy = p / 256;
         if (p == 0) mode_m = convert_type;
         nn = n_of(mode_m);
         e.cyc = cyc + 1;
         if (mode_m[2]) begin
            e.pix = src_m(xx * nn / 256, yy * nn / 256);
            sb.push_back(e);
            pushed++;
         end else if (kept(xx, nn) && kept(yy, nn)) begin
            e.pix = src_m(xx, yy);
            sb.push_back(e);
            pushed++;
         end
         @(posedge clk);
         #1;
         p = (p + 1) % 65536;
      end
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
      chk(sb.size() == 0, "sb_drained", sb.size(), 0);
   endtask

   // Called only after settle(), i.e. between a negedge and the next posedge.
   task automatic do_reset(input logic [2:0] m);
      rst_n = 1'b0;
      #1;
      chk(write_en === 1'b0, "async_rst_we", {31'd0, write_en}, 0);
      chk(LCD_RGB === 16'h0000, "async_rst_rgb", int'(LCD_RGB), 0);
      sb.delete();
      convert_type = m;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      p = 0;
   endtask

   initial begin
      int b, pb;
      #1;
      rst_n = 1'b0;
      fork
         monitor();
      join_none

      // DS_64: first pulse at edge 771 (x=3,y=3), 58 pulses in edges 0..999.
      do_reset(3'd3);
      b = pulses;
      run(772);
      settle();
      chk(pulses - b == 1, "ds64_first_pulse_count", pulses - b, 1);
      chk(last_act == 16'h0000, "ds64_first_pixel", int'(last_act), 0);
      run(228);
      settle();
      chk(pulses - b == 58, "ds64_pulses_1000", pulses - b, 58);

      // DS_128 full frame; mid-frame switch to US_96 must wait for the next frame.
      do_reset(3'd1);
      b = pulses;
      run(1000);
      convert_type = 3'd6;
      run(64536);
      settle();
      chk(pulses - b == 16384, "ds128_frame_pulses", pulses - b, 16384);
      chk(last_act == 16'hFFE0, "ds128_last_pixel", int'(last_act), 16'hFFE0);
      b = pulses;
      run(600);
      settle();
      chk(pulses - b == 600, "us96_next_frame_pulses", pulses - b, 600);

      // US_128: edges 0..15 give 0, edge 16 gives src(8,0).
      do_reset(3'd5);
      b = pulses;
      run(16);
      settle();
      chk(last_act == 16'h0000, "us128_edge15", int'(last_act), 0);
      chk(pulses - b == 16, "us128_pulses16", pulses - b, 16);
      run(1);
      settle();
      chk(last_act == 16'h0801, "us128_edge16", int'(last_act), 16'h0801);

      // US_64 short run, every position emitted.
      do_reset(3'd7);
      b = pulses;
      run(300);
      settle();
      chk(pulses - b == 300, "us64_pulses", pulses - b, 300);

      // DS_96: reset right after an emitted position, then restart from p=0.
      do_reset(3'd2);
      b = pulses;
      run(515);
      settle();
      chk(write_en === 1'b1, "ds96_pulse_before_rst", {31'd0, write_en}, 1);
      chk(pulses - b == 1, "ds96_pulses_515", pulses - b, 1);
      do_reset(3'd2);
      b = pulses;
      run(1000);
      settle();
      chk(pulses - b == 96, "ds96_pulses_1000", pulses - b, 96);

      // Random modes and lengths with ignored mid-frame mode changes.
      for (int k = 0; k < 5; k++) begin
         do_reset(3'($urandom_range(0, 7)));
         b  = pulses;
         pb = pushed;
         run(int'($urandom_range(300, 1200)));
         convert_type = 3'($urandom_range(0, 7));
         run(int'($urandom_range(100, 400)));
         settle();
         chk(pulses - b == pushed - pb, "rand_pulse_count", pulses - b, pushed - pb);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
